ttt_token_accumulator: RTL and testbench

TTT_TOKEN_ACCUMULATOR -- requirements
Module: ttt_token_accumulator

---
 rtl/ttt_token_accumulator.sv | 223 ++++++++++++++++++++++
 tb/tb_ttt_token_accumulator.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_token_accumulator.sv
// ---------------------------------------------------------------------------
// ttt_token_accumulator
//
// Purpose: keeps saturating good/bad token counters for each processor. A
// processor is "running" while good >= GOOD_THRESHOLD and bad < BAD_THRESHOLD.
// Every change of a running bit pushes a start (2'b01) or stop (2'b10) event
// into a small FIFO. A clear request scans every processor, emits a stop
// event for each one that is running, and zeroes its counters.
//
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   valid_in, target_id              token update request and addressed processor
//   new_good_tokens, new_bad_tokens  signed counter deltas
//   ready_out                        update is accepted this cycle when high
//   clear_in                         single-cycle request to stop and zero all
//   valid_out, event_ready           event handshake, head leaves when both high
//   source_id, token_startstop       head event payload (zero when FIFO empty)
//   busy                             high while the clear scan runs
//   drop_count                       (TTT_ACC_DROP_COUNT_EN only) saturating
//                                    count of cycles with valid_in && !ready_out
//
// Optional feature macro: TTT_ACC_DROP_COUNT_EN
// ---------------------------------------------------------------------------
module ttt_token_accumulator #(
  parameter int unsigned NUM_PROCESSORS  = 10,
  parameter int unsigned NEW_TOKENS_BITS = 4,
  parameter int unsigned TOKEN_BITS      = 8,
  parameter int unsigned GOOD_THRESHOLD  = 4,
  parameter int unsigned BAD_THRESHOLD   = 1,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              valid_in,
  input  logic [$clog2(NUM_PROCESSORS)-1:0] target_id,
  input  logic [NEW_TOKENS_BITS-1:0]        new_good_tokens,
  input  logic [NEW_TOKENS_BITS-1:0]        new_bad_tokens,
  output logic                              ready_out,
  input  logic                              clear_in,
  output logic                              valid_out,
  input  logic                              event_ready,
  output logic [$clog2(NUM_PROCESSORS)-1:0] source_id,
  output logic [1:0]                        token_startstop,
  output logic                              busy
`ifdef TTT_ACC_DROP_COUNT_EN
  ,
  output logic [7:0]                        drop_count
`endif
);

  localparam int unsigned ID_W  = $clog2(NUM_PROCESSORS);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned EV_W  = ID_W + 2;
  localparam int unsigned SUM_W =
    ((TOKEN_BITS > NEW_TOKENS_BITS) ? TOKEN_BITS : NEW_TOKENS_BITS) + 2;

  localparam logic [TOKEN_BITS-1:0] CNT_MAX = '1;
  localparam logic [TOKEN_BITS-1:0] GOOD_TH = TOKEN_BITS'(GOOD_THRESHOLD);
  localparam logic [TOKEN_BITS-1:0] BAD_TH  = TOKEN_BITS'(BAD_THRESHOLD);
  localparam logic [1:0]            EV_START = 2'b01;
  localparam logic [1:0]            EV_STOP  = 2'b10;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  // Counter plus sign-extended delta, clamped to [0, CNT_MAX].
  function automatic logic [TOKEN_BITS-1:0] sat_add(
    input logic        [TOKEN_BITS-1:0]      cnt,
    input logic signed [NEW_TOKENS_BITS-1:0] delta
  );
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(cnt) + SUM_W'(delta);
    if (sum[SUM_W-1]) begin
      sat_add = '0;
    end else if (|sum[SUM_W-2:TOKEN_BITS]) begin
      sat_add = CNT_MAX;
    end else begin
      sat_add = sum[TOKEN_BITS-1:0];
    end
  endfunction

  state_t                  state_q, state_d;
  logic [ID_W-1:0]         idx_q, idx_d;
  logic [TOKEN_BITS-1:0]   good_q [NUM_PROCESSORS];
  logic [TOKEN_BITS-1:0]   bad_q  [NUM_PROCESSORS];
  logic                    run_q  [NUM_PROCESSORS];

  logic [EV_W-1:0]         mem_q [FIFO_DEPTH];
  logic [AW:0]             wr_ptr_q, rd_ptr_q;
  logic                    fifo_full, fifo_empty;
  logic                    deq;

  logic                    upd_en;
  logic [ID_W-1:0]         upd_id;
  logic [TOKEN_BITS-1:0]   upd_good, upd_bad;
  logic                    upd_run;
  logic                    enq;
  logic [EV_W-1:0]         enq_data;

  // Extra pointer MSB separates full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign deq        = !fifo_empty && event_ready;

  // A clear request in IDLE takes priority, so the update is refused that cycle.
  assign ready_out       = (state_q == S_IDLE) && !fifo_full && !clear_in;
  assign valid_out       = !fifo_empty;
  assign busy            = (state_q == S_CLEAR);
  assign source_id       = fifo_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]][EV_W-1:2];
  assign token_startstop = fifo_empty ? 2'b00 : mem_q[rd_ptr_q[AW-1:0]][1:0];

  // Next-state, counter update and event generation.
  always_comb begin
    logic [TOKEN_BITS-1:0] g_new;
    logic [TOKEN_BITS-1:0] b_new;
    logic                  r_new;

    state_d  = state_q;
    idx_d    = idx_q;
    upd_en   = 1'b0;
    upd_id   = '0;
    upd_good = '0;
    upd_bad  = '0;
    upd_run  = 1'b0;
    enq      = 1'b0;
    enq_data = '0;
    g_new    = '0;
    b_new    = '0;
    r_new    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (clear_in) begin
          state_d = S_CLEAR;
          idx_d   = '0;
        end else if (valid_in && !fifo_full) begin
          // Out-of-range ids are consumed without touching any state.
          if (32'(target_id) < NUM_PROCESSORS) begin
            g_new    = sat_add(good_q[target_id], new_good_tokens);
            b_new    = sat_add(bad_q[target_id], new_bad_tokens);
            r_new    = (g_new >= GOOD_TH) && (b_new < BAD_TH);
            upd_en   = 1'b1;
            upd_id   = target_id;
            upd_good = g_new;
            upd_bad  = b_new;
            upd_run  = r_new;
            if (r_new != run_q[target_id]) begin
              enq      = 1'b1;
              enq_data = {target_id, (r_new ? EV_START : EV_STOP)};
            end
          end
        end
      end
      S_CLEAR: begin
        // One processor per cycle; stall while the FIFO cannot take a stop event.
        if (!fifo_full) begin
          upd_en = 1'b1;
          upd_id = idx_q;
          if (run_q[idx_q]) begin
            enq      = 1'b1;
            enq_data = {idx_q, EV_STOP};
          end
          if (32'(idx_q) == NUM_PROCESSORS - 1) begin
            state_d = S_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + ID_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and FIFO pointers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(NUM_PROCESSORS); i++) begin
        good_q[i] <= '0;
        bad_q[i]  <= '0;
        run_q[i]  <= 1'b0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (upd_en) begin
        good_q[upd_id] <= upd_good;
        bad_q[upd_id]  <= upd_bad;
        run_q[upd_id]  <= upd_run;
      end
      if (enq) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (deq) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Event storage; contents are only visible while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q[AW-1:0]] <= enq_data;
  end

`ifdef TTT_ACC_DROP_COUNT_EN
  logic [7:0] drop_q;

  // Saturating count of refused update cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else if (valid_in && !ready_out && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_ttt_token_accumulator.sv
// ---------------------------------------------------------------------------
// tb_ttt_token_accumulator
//
// Directed bench for ttt_token_accumulator. Main instance uses default
// parameters; a second instance with TOKEN_BITS=4 covers counter saturation.
// ---------------------------------------------------------------------------
module tb_ttt_token_accumulator;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [3:0] target_id;
  logic [3:0] new_good_tokens;
  logic [3:0] new_bad_tokens;
  logic       ready_out;
  logic       clear_in;
  logic       valid_out;
  logic       event_ready;
  logic [3:0] source_id;
  logic [1:0] token_startstop;
  logic       busy;

  logic       s_valid;
  logic [3:0] s_id;
  logic [3:0] s_good;
  logic [3:0] s_bad;
  logic       s_ready;
  logic       s_clear;
  logic       s_vout;
  logic       s_evrdy;
  logic [3:0] s_src;
  logic [1:0] s_tss;
  logic       s_busy;

`ifdef TTT_ACC_DROP_COUNT_EN
  logic [7:0] drop_count;
  logic [7:0] s_drop;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ttt_token_accumulator u_dut (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (valid_in),
    .target_id       (target_id),
    .new_good_tokens (new_good_tokens),
    .new_bad_tokens  (new_bad_tokens),
    .ready_out       (ready_out),
    .clear_in        (clear_in),
    .valid_out       (valid_out),
    .event_ready     (event_ready),
    .source_id       (source_id),
    .token_startstop (token_startstop),
    .busy            (busy)
`ifdef TTT_ACC_DROP_COUNT_EN
    ,
    .drop_count      (drop_count)
`endif
  );

  ttt_token_accumulator #(.TOKEN_BITS(4)) u_sat (
    .clk             (clk),
    .reset           (reset),
    .valid_in        (s_valid),
    .target_id       (s_id),
    .new_good_tokens (s_good),
    .new_bad_tokens  (s_bad),
    .ready_out       (s_ready),
    .clear_in        (s_clear),
    .valid_out       (s_vout),
    .event_ready     (s_evrdy),
    .source_id       (s_src),
    .token_startstop (s_tss),
    .busy            (s_busy)
`ifdef TTT_ACC_DROP_COUNT_EN
    ,
    .drop_count      (s_drop)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] id, input logic [3:0] g, input logic [3:0] b);
    valid_in        = 1'b1;
    target_id       = id;
    new_good_tokens = g;
    new_bad_tokens  = b;
    tick();
    valid_in        = 1'b0;
  endtask

  task automatic s_send(input logic [3:0] id, input logic [3:0] g, input logic [3:0] b);
    s_valid = 1'b1;
    s_id    = id;
    s_good  = g;
    s_bad   = b;
    tick();
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    clear_in = 1'b0;
    s_valid  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int nb;
    int ne;
    int seen;
    logic [3:0] ev_src [4];
    logic [1:0] ev_tss [4];

    reset           = 1'b1;
    valid_in        = 1'b0;
    target_id       = '0;
    new_good_tokens = '0;
    new_bad_tokens  = '0;
    clear_in        = 1'b0;
    event_ready     = 1'b1;
    s_valid         = 1'b0;
    s_id            = '0;
    s_good          = '0;
    s_bad           = '0;
    s_clear         = 1'b0;
    s_evrdy         = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ev_src[i] = '0;
      ev_tss[i] = '0;
    end

    // Reset values
    tick();
    tick();
    check("rst_valid_out", 32'(valid_out), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_source_id", 32'(source_id), 32'd0);
    check("rst_startstop", 32'(token_startstop), 32'd0);
    reset = 1'b0;
    #1;
    check("rst_ready_out", 32'(ready_out), 32'd1);
`ifdef TTT_ACC_DROP_COUNT_EN
    check("rst_drop_count", 32'(drop_count), 32'd0);
`endif

    // Start then stop on id 3, good saturating at zero
    send(4'd3, 4'd4, 4'd0);
    check("start3_valid", 32'(valid_out), 32'd1);
    check("start3_id", 32'(source_id), 32'd3);
    check("start3_ss", 32'(token_startstop), 32'h1);
    send(4'd3, 4'd0, 4'd1);
    check("stop3_valid", 32'(valid_out), 32'd1);
    check("stop3_id", 32'(source_id), 32'd3);
    check("stop3_ss", 32'(token_startstop), 32'h2);
    send(4'd3, 4'h8, 4'd0);
    check("good_neg8_no_ev", 32'(valid_out), 32'd0);
    send(4'd3, 4'd0, 4'hF);
    check("bad_to0_no_ev", 32'(valid_out), 32'd0);
    send(4'd3, 4'd3, 4'd0);
    check("good3_no_ev", 32'(valid_out), 32'd0);
    send(4'd3, 4'd1, 4'd0);
    check("good4_start_ss", 32'(token_startstop), 32'h1);

    // FIFO fill with consumer stalled
    do_reset();
    event_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fill_ready_%0d", i), 32'(ready_out), 32'd1);
      send(4'(i), 4'd4, 4'd0);
    end
    check("full_ready_low", 32'(ready_out), 32'd0);
    check("full_valid", 32'(valid_out), 32'd1);
    valid_in        = 1'b1;
    target_id       = 4'd4;
    new_good_tokens = 4'd4;
    new_bad_tokens  = 4'd0;
    tick();
`ifdef TTT_ACC_DROP_COUNT_EN
    check("drop_count_1", 32'(drop_count), 32'd1);
`endif
    check("stall_ready_low", 32'(ready_out), 32'd0);
    valid_in    = 1'b0;
    event_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain_id_%0d", i), 32'(source_id), 32'(i));
      check($sformatf("drain_ss_%0d", i), 32'(token_startstop), 32'h1);
      tick();
    end
    check("fifth_ignored", 32'(valid_out), 32'd0);
    check("drain_ready", 32'(ready_out), 32'd1);

    // Out-of-range id is swallowed
    send(4'd12, 4'd4, 4'd0);
    check("oor_no_ev", 32'(valid_out), 32'd0);

    // Clear scan with ids 1 and 7 running; id 2 update collides with clear
    do_reset();
    send(4'd1, 4'd4, 4'd0);
    send(4'd7, 4'd4, 4'd0);
    send(4'd5, 4'd2, 4'd0);
    tick();
    check("pre_clear_empty", 32'(valid_out), 32'd0);
    clear_in        = 1'b1;
    valid_in        = 1'b1;
    target_id       = 4'd2;
    new_good_tokens = 4'd4;
    new_bad_tokens  = 4'd0;
    #1;
    check("clear_wins_ready", 32'(ready_out), 32'd0);
    tick();
    clear_in = 1'b0;
    valid_in = 1'b0;
    nb = 0;
    ne = 0;
    for (int c = 0; c < 20; c++) begin
      if (busy) nb++;
      if (valid_out) begin
        if (ne < 4) begin
          ev_src[ne] = source_id;
          ev_tss[ne] = token_startstop;
        end
        ne++;
      end
      tick();
    end
    check("clear_busy_cycles", 32'(nb), 32'd10);
    check("clear_event_count", 32'(ne), 32'd2);
    check("clear_ev0_id", 32'(ev_src[0]), 32'd1);
    check("clear_ev0_ss", 32'(ev_tss[0]), 32'h2);
    check("clear_ev1_id", 32'(ev_src[1]), 32'd7);
    check("clear_ev1_ss", 32'(ev_tss[1]), 32'h2);
    check("clear_done_busy", 32'(busy), 32'd0);
    send(4'd5, 4'd2, 4'd0);
    check("id5_zeroed", 32'(valid_out), 32'd0);
    send(4'd1, 4'd3, 4'd0);
    check("id1_zeroed", 32'(valid_out), 32'd0);

    // Reset in the middle of a clear with events queued
    event_ready = 1'b0;
    send(4'd1, 4'd1, 4'd0);
    send(4'd7, 4'd4, 4'd0);
    check("queued_valid", 32'(valid_out), 32'd1);
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
    tick();
    check("mid_clear_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(valid_out), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_src", 32'(source_id), 32'd0);
    check("async_rst_ss", 32'(token_startstop), 32'd0);
    tick();
    reset       = 1'b0;
    event_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      if (valid_out) seen++;
      tick();
    end
    check("post_rst_no_events", 32'(seen), 32'd0);
    check("post_rst_ready", 32'(ready_out), 32'd1);
    send(4'd1, 4'd3, 4'd0);
    check("post_rst_zeroed", 32'(valid_out), 32'd0);

    // Saturation with TOKEN_BITS=4
    check("sat_ready", 32'(s_ready), 32'd1);
    s_send(4'd0, 4'd7, 4'd0);
    check("sat_start_valid", 32'(s_vout), 32'd1);
    check("sat_start_id", 32'(s_src), 32'd0);
    check("sat_start_ss", 32'(s_tss), 32'h1);
    s_send(4'd0, 4'd7, 4'd0);
    check("sat_14_no_ev", 32'(s_vout), 32'd0);
    s_send(4'd0, 4'd7, 4'd0);
    check("sat_15_no_ev", 32'(s_vout), 32'd0);
    s_send(4'd0, 4'd0, 4'hD);
    check("sat_bad_floor", 32'(s_vout), 32'd0);
    s_send(4'd0, 4'h8, 4'd0);
    check("sat_good_15_minus_8", 32'(s_vout), 32'd0);
    s_send(4'd0, 4'd0, 4'd1);
    check("sat_stop_valid", 32'(s_vout), 32'd1);
    check("sat_stop_ss", 32'(s_tss), 32'h2);
    check("sat_busy", 32'(s_busy), 32'd0);
`ifdef TTT_ACC_DROP_COUNT_EN
    check("sat_drop", 32'(s_drop), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
